// File: rtl/vram_pkg.sv
// vram_pkg: shared widths, read-pipeline tag type and write-buffer sizing
// for the framebuffer VRAM arbiter.
package vram_pkg;

  localparam int ADDR_W      = 18;  // framebuffer word address width
  localparam int DATA_W      = 12;  // 4:4:4 RGB pixel word
  localparam int STALL_W     = 16;  // CPU stall statistics counter width
  localparam int RD_LATENCY  = 3;   // request cycle to rvalid cycle
  localparam int WRBUF_DEPTH = 4;   // posted write FIFO entries

  // Identifies who owns the read data travelling down the SRAM pipeline.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_DISP   = 2'd1,
    TAG_CPU_RD = 2'd2
  } tag_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display fetch, CPU bus and SRAM signals of the VRAM
// arbiter. The slave modport is the arbiter view; master is the
// environment (fetcher, CPU and SRAM) view.
interface vram_arbiter_if #(
  parameter int ADDR_W  = vram_pkg::ADDR_W,
  parameter int DATA_W  = vram_pkg::DATA_W,
  parameter int STALL_W = vram_pkg::STALL_W
);

  logic               disp_req;
  logic [ADDR_W-1:0]  disp_addr;
  logic               disp_rvalid;
  logic [DATA_W-1:0]  disp_rdata;

  logic               cpu_valid;
  logic               cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_wdata;
  logic               cpu_ready;
  logic               cpu_rvalid;
  logic [DATA_W-1:0]  cpu_rdata;

  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;

  logic [STALL_W-1:0] cpu_stall_cycles;

  modport slave (
    input  disp_req, disp_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output disp_rvalid, disp_rdata, cpu_ready, cpu_rvalid, cpu_rdata,
    output mem_addr, mem_we, mem_wdata, cpu_stall_cycles
  );

  modport master (
    output disp_req, disp_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  disp_rvalid, disp_rdata, cpu_ready, cpu_rvalid, cpu_rdata,
    input  mem_addr, mem_we, mem_wdata, cpu_stall_cycles
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: small posted-write FIFO holding {addr, data} pairs.
// A push while full is accepted only if a pop happens in the same cycle.
// Used by vram_arbiter only when VRAM_ARB_WRBUF_EN is defined.
module vram_wr_fifo #(
  parameter int AW    = vram_pkg::ADDR_W,
  parameter int DW    = vram_pkg::DATA_W,
  parameter int DEPTH = vram_pkg::WRBUF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [AW+DW-1:0] store_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (PW+1)'(DEPTH));
  assign empty     = (count_r == {(PW+1){1'b0}});
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign {head_addr, head_data} = store_r[rd_ptr_r];

  // Payload storage: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      store_r[wr_ptr_r] <= {push_addr, push_data};
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous SRAM between display
// scanout (always wins) and the CPU bus (uses idle slots). Read data is
// steered back by a 2-stage tag pipeline aligned with mem_rdata.
// Optional feature: define VRAM_ARB_WRBUF_EN for a 4-entry posted write FIFO.
module vram_arbiter #(
  parameter int ADDR_W  = vram_pkg::ADDR_W,
  parameter int DATA_W  = vram_pkg::DATA_W,
  parameter int STALL_W = vram_pkg::STALL_W
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);
  import vram_pkg::*;

  logic               rd_out_r;
  logic               rd_busy_s;
  logic               rd_accept_s;
  logic               cpu_ready_s;
  logic               stall_inc_s;

  logic               slot_valid_s;
  logic               slot_we_s;
  logic [ADDR_W-1:0]  slot_addr_s;
  logic [DATA_W-1:0]  slot_wdata_s;
  tag_e               slot_tag_s;

  tag_e               tag_s1_r;
  tag_e               tag_s2_r;

  logic [ADDR_W-1:0]  mem_addr_r;
  logic               mem_we_r;
  logic [DATA_W-1:0]  mem_wdata_r;
  logic               disp_rvalid_r;
  logic [DATA_W-1:0]  disp_rdata_r;
  logic               cpu_rvalid_r;
  logic [DATA_W-1:0]  cpu_rdata_r;
  logic [STALL_W-1:0] stall_r;

  // The outstanding read retires in the cycle its rvalid is shown, so a new
  // read can be accepted in that same cycle.
  assign rd_busy_s = rd_out_r & ~cpu_rvalid_r;

`ifdef VRAM_ARB_WRBUF_EN
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [ADDR_W-1:0] fifo_addr_s;
  logic [DATA_W-1:0] fifo_data_s;

  // Drains use every display-idle slot; reads wait until the FIFO is empty
  // so they can never overtake a posted write.
  assign fifo_pop_s  = ~bus.disp_req & ~fifo_empty_s;
  assign cpu_ready_s = ~rst & bus.cpu_valid &
                       (bus.cpu_we ? (~fifo_full_s | fifo_pop_s)
                                   : (~rd_busy_s & fifo_empty_s & ~bus.disp_req));
  assign fifo_push_s = cpu_ready_s & bus.cpu_we;

  vram_wr_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (WRBUF_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_addr (bus.cpu_addr),
    .push_data (bus.cpu_wdata),
    .pop       (fifo_pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head_addr (fifo_addr_s),
    .head_data (fifo_data_s)
  );

  // Slot owner: display, else FIFO drain, else CPU read, else idle.
  always_comb begin
    slot_valid_s = 1'b0;
    slot_we_s    = 1'b0;
    slot_addr_s  = {ADDR_W{1'b0}};
    slot_wdata_s = {DATA_W{1'b0}};
    slot_tag_s   = TAG_NONE;
    if (bus.disp_req) begin
      slot_valid_s = 1'b1;
      slot_addr_s  = bus.disp_addr;
      slot_tag_s   = TAG_DISP;
    end else if (fifo_pop_s) begin
      slot_valid_s = 1'b1;
      slot_we_s    = 1'b1;
      slot_addr_s  = fifo_addr_s;
      slot_wdata_s = fifo_data_s;
    end else if (rd_accept_s) begin
      slot_valid_s = 1'b1;
      slot_addr_s  = bus.cpu_addr;
      slot_tag_s   = TAG_CPU_RD;
    end else begin
      slot_valid_s = 1'b0;
    end
  end
`else
  assign cpu_ready_s = ~rst & bus.cpu_valid & (bus.cpu_we | ~rd_busy_s) & ~bus.disp_req;

  // Slot owner: display, else an accepted CPU access, else idle.
  always_comb begin
    slot_valid_s = 1'b0;
    slot_we_s    = 1'b0;
    slot_addr_s  = {ADDR_W{1'b0}};
    slot_wdata_s = {DATA_W{1'b0}};
    slot_tag_s   = TAG_NONE;
    if (bus.disp_req) begin
      slot_valid_s = 1'b1;
      slot_addr_s  = bus.disp_addr;
      slot_tag_s   = TAG_DISP;
    end else if (cpu_ready_s) begin
      slot_valid_s = 1'b1;
      slot_we_s    = bus.cpu_we;
      slot_addr_s  = bus.cpu_addr;
      slot_wdata_s = bus.cpu_wdata;
      slot_tag_s   = bus.cpu_we ? TAG_NONE : TAG_CPU_RD;
    end else begin
      slot_valid_s = 1'b0;
    end
  end
`endif

  assign rd_accept_s = cpu_ready_s & ~bus.cpu_we;
  assign stall_inc_s = bus.cpu_valid & ~cpu_ready_s;

  // Register the winning access onto the SRAM port; idle slots hold the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      mem_we_r <= slot_we_s;
      if (slot_valid_s) begin
        mem_addr_r <= slot_addr_s;
      end
      if (slot_we_s) begin
        mem_wdata_r <= slot_wdata_s;
      end
    end
  end

  // Tag pipeline and read-data return; reset drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_s1_r      <= TAG_NONE;
      tag_s2_r      <= TAG_NONE;
      disp_rvalid_r <= 1'b0;
      disp_rdata_r  <= {DATA_W{1'b0}};
      cpu_rvalid_r  <= 1'b0;
      cpu_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      tag_s1_r      <= slot_tag_s;
      tag_s2_r      <= tag_s1_r;
      disp_rvalid_r <= (tag_s2_r == TAG_DISP);
      cpu_rvalid_r  <= (tag_s2_r == TAG_CPU_RD);
      if (tag_s2_r == TAG_DISP) begin
        disp_rdata_r <= bus.mem_rdata;
      end
      if (tag_s2_r == TAG_CPU_RD) begin
        cpu_rdata_r <= bus.mem_rdata;
      end
    end
  end

  // Single-outstanding CPU read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_out_r <= 1'b0;
    end else if (rd_accept_s) begin
      rd_out_r <= 1'b1;
    end else if (cpu_rvalid_r) begin
      rd_out_r <= 1'b0;
    end
  end

  // Saturating count of cycles where the CPU waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r <= {STALL_W{1'b0}};
    end else if (stall_inc_s && (stall_r != {STALL_W{1'b1}})) begin
      stall_r <= stall_r + {{(STALL_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.cpu_ready        = cpu_ready_s;
  assign bus.mem_addr         = mem_addr_r;
  assign bus.mem_we           = mem_we_r;
  assign bus.mem_wdata        = mem_wdata_r;
  assign bus.disp_rvalid      = disp_rvalid_r;
  assign bus.disp_rdata       = disp_rdata_r;
  assign bus.cpu_rvalid       = cpu_rvalid_r;
  assign bus.cpu_rdata        = cpu_rdata_r;
  assign bus.cpu_stall_cycles = stall_r;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous framebuffer SRAM between two requesters: display scanout reads (hard real-time) and the memory-mapped CPU bus (reads/writes).
- Sits between the pixel-timing generator's fetch logic and the SRAM.
- Display always wins; CPU accesses use display-idle slots (blanking, or gaps when the fetcher does not request).

Parameters:
- ADDR_W, 18, framebuffer word address width (640x350 = 224000 words fits).
- DATA_W, 12, pixel word width (4:4:4 RGB).
- STALL_W, 16, width of the CPU stall statistics counter.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-high reset
- disp_req  in  1  display read request, sampled every cycle, no backpressure
- disp_addr  in  ADDR_W  display read address
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  DATA_W  display read data
- cpu_valid  in  1  CPU request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  CPU request accepted this cycle when high with cpu_valid
- cpu_rvalid  out  1  CPU read data valid, single-cycle pulse
- cpu_rdata  out  DATA_W  CPU read data
- mem_addr  out  ADDR_W  SRAM address, registered
- mem_we  out  1  SRAM write enable, registered
- mem_wdata  out  DATA_W  SRAM write data, registered
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after address presented
- cpu_stall_cycles  out  STALL_W  saturating count of cycles with cpu_valid high and cpu_ready low

Behaviour:
- Reset (async, rst high): all outputs 0; pipeline tags cleared; any in-flight read is discarded, with no rvalid after reset.
- Slot decision in cycle t: if disp_req, the display owns the slot. Else if a CPU request is eligible, the CPU owns it. Else the slot is idle.
- The winning access is registered onto mem_* at the end of cycle t.
- Idle slot: mem_we = 0; mem_addr holds its last value.
- mem_we is high only for CPU write slots.
- Pipeline carries a 2-bit tag {NONE, DISP, CPU_RD} for 2 stages, aligned with mem_rdata.
- Display latency is fixed: disp_req at cycle t gives disp_rvalid = 1 and disp_rdata = word at disp_addr in cycle t+3. disp_rdata is registered from mem_rdata.
- CPU read latency is 3 cycles after acceptance, same path; cpu_rvalid pulses for 1 cycle.
- CPU eligibility: cpu_valid = 1 and no CPU read outstanding (at most 1 in flight).
- cpu_ready = eligible and not disp_req (combinational from registered state and current inputs).
- Read-outstanding flag: set on read acceptance, cleared in the cycle cpu_rvalid is asserted. A new read may be accepted in that same cycle.
- Write accepted at t is visible to a display or CPU read issued at t+1 or later. Ordering is strict slot order.
- Simultaneous disp_req and cpu_valid: display granted, CPU stalls, stall counter increments.
- cpu_stall_cycles saturates at all-ones; it does not wrap.
- cpu_valid may drop without a handshake; nothing is issued.

Optional Feature:
- Macro VRAM_ARB_WRBUF_EN.
- With the macro: a 4-entry posted write FIFO.
  - CPU writes are accepted whenever the FIFO is not full, regardless of disp_req.
  - FIFO drains on idle slots, head entry first. A CPU read takes priority over a drain only when the FIFO is empty.
  - A CPU read is not eligible while the FIFO is non-empty, which preserves read-after-write ordering.
  - Full FIFO: cpu_ready = 0 for writes, and the stall counter increments.
  - Simultaneous push and drain when full: the drain frees an entry, so the push is accepted.
- Without the macro: writes are accepted only on a granted slot, as above.

Decomposition:
- Package vram_pkg holds:
  - ADDR_W/DATA_W defaults
  - RD_LATENCY = 3
  - the tag type {TAG_NONE, TAG_DISP, TAG_CPU_RD}
  - WRBUF_DEPTH = 4
- Sub-module vram_wr_fifo: push/pop, full/empty, {addr, data} payload, async reset. It is instantiated only under VRAM_ARB_WRBUF_EN.

Test Plan:
- Display-only burst: disp_req high for 640 cycles, addr 0..639 -> disp_rvalid high for 640 cycles, starting 3 cycles later, data equal to preloaded pattern; mem_we stays 0.
- CPU write then read in blanking: write addr 0x100 data 0xABC, then read 0x100 -> cpu_rvalid 3 cycles after read accept, cpu_rdata = 0xABC.
- Contention: disp_req and cpu_valid (write) high together for 10 cycles -> cpu_ready 0 throughout, cpu_stall_cycles = 10, write lands in the cycle after disp_req drops.
- Single outstanding read: cpu_valid held with reads to 0x10 and 0x11 -> second accepted only in the cycle the first returns its rvalid; responses in order.
- Reset mid-read: assert rst 1 cycle after a CPU read accept -> all outputs 0, no cpu_rvalid ever appears for that read.
- With VRAM_ARB_WRBUF_EN: 5 back-to-back writes during disp_req -> 4 accepted, 5th stalls. Drain after disp_req drops; a read to the 4th write address returns its data.
